// File: rtl/pattern_detector_gen.sv
// pattern_detector_gen
//   Streaming symbol-pattern detector with a programmable run threshold.
//   Keeps an NSYM-symbol window of valid input symbols (newest in the LS
//   slot), compares the would-be window against `pattern` and counts
//   back-to-back matches. When a run reaches n (0 treated as 1) a one-cycle
//   pulse is produced on the clock after the completing symbol.
//
//   Optional build macro: PATTERN_DETECTOR_GEN_MASK_EN adds the pattern_mask
//   input (0 bit = don't care). Without it all bits are compared exactly.
//
// Ports
//   CLK, RSTn         clock, asynchronous active-low reset
//   clr               synchronous soft clear (wins over in_valid)
//   in_valid/in_data  qualified input symbol stream
//   pattern           target pattern, MS symbol received first
//   pattern_mask      (MASK_EN only) per-bit compare enable
//   overlap           1 = overlapping matches allowed
//   n                 matches per detection
//   pattern_detected  one-cycle pulse when the run reaches n
//   detect_sticky     set by pattern_detected, cleared by clr/reset
//   match_cnt         current run length
//   locked            FSM is in LOCK
//
// State  | meaning
// -------+------------------------------------------------------------
// FILL   | fewer than NSYM symbols stored, no run in progress
// SEARCH | window full, waiting for the first match of a run
// LOCK   | run in progress; up to NSYM-1 non-matching symbols tolerated

module pattern_detector_gen #(
  parameter int DATA_W = 8,
  parameter int NSYM   = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [NSYM*DATA_W-1:0] pattern,
`ifdef PATTERN_DETECTOR_GEN_MASK_EN
  input  logic [NSYM*DATA_W-1:0] pattern_mask,
`endif
  input  logic                   overlap,
  input  logic [CNT_W-1:0]       n,
  output logic                   pattern_detected,
  output logic                   detect_sticky,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   locked
);

  localparam int WIN_W  = NSYM * DATA_W;
  localparam int FILL_W = $clog2(NSYM + 1);
  localparam int GAP_W  = $clog2(NSYM);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIN_W-1:0]    window_q, window_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                det_q, det_d;
  logic                sticky_q, sticky_d;

  logic [WIN_W-1:0]    win_shift;
  logic [WIN_W-1:0]    diff;
  logic                match;
  logic [CNT_W:0]      n_eff;
  logic [CNT_W:0]      cnt_inc;
  logic                run_done;

  // Match is evaluated on the window as it would look after this symbol.
  assign win_shift = {window_q[WIN_W-DATA_W-1:0], in_data};

`ifdef PATTERN_DETECTOR_GEN_MASK_EN
  assign diff = (win_shift ^ pattern) & pattern_mask;
`else
  assign diff = win_shift ^ pattern;
`endif

  assign match = in_valid && (fill_q >= FILL_W'(NSYM - 1)) && (diff == '0);

  // One extra bit keeps match_cnt+1 from wrapping at CNT_W.
  assign n_eff    = (n == '0) ? (CNT_W+1)'(1) : {1'b0, n};
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign run_done = cnt_inc >= n_eff;

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    det_d    = 1'b0;
    sticky_d = sticky_q;

    if (in_valid) begin
      window_d = win_shift;

      // Non-overlapping mode forgets the window so the next match needs
      // NSYM fresh symbols.
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q < FILL_W'(NSYM)) begin
        fill_d = fill_q + FILL_W'(1);
      end

      if (match) begin
        state_d = LOCK;
        gap_d   = '0;
        if (run_done) begin
          det_d    = 1'b1;
          sticky_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end else begin
        case (state_q)
          FILL: begin
            if (fill_d == FILL_W'(NSYM)) state_d = SEARCH;
          end
          SEARCH: begin
            state_d = SEARCH;
          end
          LOCK: begin
            if (gap_q == GAP_W'(NSYM - 1)) begin
              cnt_d   = '0;
              gap_d   = '0;
              state_d = (fill_d < FILL_W'(NSYM)) ? FILL : SEARCH;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
          default: begin
            state_d = FILL;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= FILL;
      window_q <= '0;
      fill_q   <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      det_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (clr) begin
      state_q  <= FILL;
      window_q <= '0;
      fill_q   <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      det_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
      sticky_q <= sticky_d;
    end
  end

  assign pattern_detected = det_q;
  assign detect_sticky    = sticky_q;
  assign match_cnt        = cnt_q;
  assign locked           = (state_q == LOCK);

endmodule

// File: tb/tb_pattern_detector_gen.sv
// Testbench for pattern_detector_gen (default parameters DATA_W=8, NSYM=4,
// CNT_W=8). Table-driven vectors plus hand-written reset/clr/mask sequences.

module tb_pattern_detector_gen;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [31:0] pattern;
`ifdef PATTERN_DETECTOR_GEN_MASK_EN
  logic [31:0] pattern_mask;
`endif
  logic        overlap;
  logic [7:0]  n;
  logic        pattern_detected;
  logic        detect_sticky;
  logic [7:0]  match_cnt;
  logic        locked;

  int n_cmp = 0;
  int n_err = 0;

  pattern_detector_gen #(.DATA_W(8), .NSYM(4), .CNT_W(8)) dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .clr              (clr),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .pattern          (pattern),
`ifdef PATTERN_DETECTOR_GEN_MASK_EN
    .pattern_mask     (pattern_mask),
`endif
    .overlap          (overlap),
    .n                (n),
    .pattern_detected (pattern_detected),
    .detect_sticky    (detect_sticky),
    .match_cnt        (match_cnt),
    .locked           (locked)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        clr;
    logic        v;
    logic [7:0]  d;
    logic [31:0] pat;
    logic        ov;
    logic [7:0]  n;
    logic        det;
    logic [7:0]  cnt;
    logic        lock;
    logic        stk;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] cfg_pat;
  logic        cfg_ov;
  logic [7:0]  cfg_n;

  task automatic add(input logic c, input logic v, input logic [7:0] d,
                     input logic det, input logic [7:0] cnt,
                     input logic lock, input logic stk);
    vec_t t;
    t.clr = c; t.v = v; t.d = d;
    t.pat = cfg_pat; t.ov = cfg_ov; t.n = cfg_n;
    t.det = det; t.cnt = cnt; t.lock = lock; t.stk = stk;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic det, input logic [7:0] cnt,
                         input logic lock, input logic stk);
    chk({nm, " det"},    {31'd0, pattern_detected}, {31'd0, det});
    chk({nm, " cnt"},    {24'd0, match_cnt},        {24'd0, cnt});
    chk({nm, " locked"}, {31'd0, locked},           {31'd0, lock});
    chk({nm, " sticky"}, {31'd0, detect_sticky},    {31'd0, stk});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic v, input logic [7:0] d);
    clr = c; in_valid = v; in_data = d;
    @(posedge CLK);
    #1;
    clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    logic [31:0] tmp;
    tmp = w;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, tmp[31:24]);
      tmp = tmp << 8;
    end
  endtask

  logic exp_mask_det;

  initial begin
    RSTn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    pattern = 32'hAABBCCDD; overlap = 1'b0; n = 8'd1;
`ifdef PATTERN_DETECTOR_GEN_MASK_EN
    pattern_mask = 32'hFFFFFFFF;
`endif

    // ---- vector table ----
    // single match, n=1, non-overlap
    cfg_pat = 32'hAABBCCDD; cfg_ov = 1'b0; cfg_n = 8'd1;
    add(0,1,8'h11, 0,0,0,0);
    add(0,1,8'hAA, 0,0,0,0);
    add(0,1,8'hBB, 0,0,0,0);
    add(0,1,8'hCC, 0,0,0,0);
    add(0,1,8'hDD, 1,0,1,1);
    add(0,0,8'h00, 0,0,1,1);
    add(1,0,8'h00, 0,0,0,0);
    // run of three back-to-back copies, n=3
    cfg_n = 8'd3;
    add(0,1,8'hAA, 0,0,0,0);
    add(0,1,8'hBB, 0,0,0,0);
    add(0,1,8'hCC, 0,0,0,0);
    add(0,1,8'hDD, 0,1,1,0);
    add(0,1,8'hAA, 0,1,1,0);
    add(0,1,8'hBB, 0,1,1,0);
    add(0,1,8'hCC, 0,1,1,0);
    add(0,1,8'hDD, 0,2,1,0);
    add(0,1,8'hAA, 0,2,1,0);
    add(0,1,8'hBB, 0,2,1,0);
    add(0,1,8'hCC, 0,2,1,0);
    add(0,1,8'hDD, 1,0,1,1);
    add(1,0,8'h00, 0,0,0,0);
    // 00 inserted before third copy: CC is the miss, DD starts a new run
    add(0,1,8'hAA, 0,0,0,0);
    add(0,1,8'hBB, 0,0,0,0);
    add(0,1,8'hCC, 0,0,0,0);
    add(0,1,8'hDD, 0,1,1,0);
    add(0,1,8'hAA, 0,1,1,0);
    add(0,1,8'hBB, 0,1,1,0);
    add(0,1,8'hCC, 0,1,1,0);
    add(0,1,8'hDD, 0,2,1,0);
    add(0,1,8'h00, 0,2,1,0);
    add(0,1,8'hAA, 0,2,1,0);
    add(0,1,8'hBB, 0,2,1,0);
    add(0,1,8'hCC, 0,0,0,0);
    add(0,1,8'hDD, 0,1,1,0);
    add(0,0,8'hDD, 0,1,1,0);
    add(1,0,8'h00, 0,0,0,0);
    // A5 repeated, overlapping
    cfg_pat = 32'hA5A5A5A5; cfg_ov = 1'b1; cfg_n = 8'd1;
    add(0,1,8'hA5, 0,0,0,0);
    add(0,1,8'hA5, 0,0,0,0);
    add(0,1,8'hA5, 0,0,0,0);
    add(0,1,8'hA5, 1,0,1,1);
    add(0,1,8'hA5, 1,0,1,1);
    add(0,1,8'hA5, 1,0,1,1);
    add(0,0,8'hA5, 0,0,1,1);
    add(1,0,8'h00, 0,0,0,0);
    // A5 repeated, non-overlapping
    cfg_ov = 1'b0;
    add(0,1,8'hA5, 0,0,0,0);
    add(0,1,8'hA5, 0,0,0,0);
    add(0,1,8'hA5, 0,0,0,0);
    add(0,1,8'hA5, 1,0,1,1);
    add(0,1,8'hA5, 0,0,1,1);
    add(0,1,8'hA5, 0,0,1,1);
    add(1,0,8'h00, 0,0,0,0);
    // gapped stream, n=0 (treated as 1)
    cfg_pat = 32'hAABBCCDD; cfg_n = 8'd0;
    add(0,1,8'hAA, 0,0,0,0);
    for (int g = 0; g < 3; g++) add(0,0,8'h00, 0,0,0,0);
    add(0,1,8'hBB, 0,0,0,0);
    for (int g = 0; g < 3; g++) add(0,0,8'h00, 0,0,0,0);
    add(0,1,8'hCC, 0,0,0,0);
    for (int g = 0; g < 3; g++) add(0,0,8'hDD, 0,0,0,0);
    add(0,1,8'hDD, 1,0,1,1);
    add(0,0,8'h00, 0,0,1,1);
    add(0,0,8'h00, 0,0,1,1);

    // ---- reset ----
    #12;
    chk_all("reset", 1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pattern = tbl[i].pat; overlap = tbl[i].ov; n = tbl[i].n;
      step(tbl[i].clr, tbl[i].v, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].det, tbl[i].cnt, tbl[i].lock, tbl[i].stk);
    end

    // ---- asynchronous reset mid-pattern (state is LOCK, sticky set) ----
    pattern = 32'hAABBCCDD; overlap = 1'b0; n = 8'd1;
    step(0, 1, 8'hAA);
    step(0, 1, 8'hBB);
    step(0, 1, 8'hCC);
    RSTn = 1'b0;
    #2;
    chk_all("rst_async", 1'b0, 8'd0, 1'b0, 1'b0);
    RSTn = 1'b1;
    step(0, 1, 8'hDD);
    chk_all("rst_dd", 1'b0, 8'd0, 1'b0, 1'b0);

    // ---- clr in the same cycle as DD ----
    step(1, 0, 8'h00);
    send4(32'hAABBCCDD);
    chk_all("clr_pre", 1'b1, 8'd0, 1'b1, 1'b1);
    step(0, 1, 8'hAA);
    step(0, 1, 8'hBB);
    step(0, 1, 8'hCC);
    step(1, 1, 8'hDD);
    chk_all("clr_dd", 1'b0, 8'd0, 1'b0, 1'b0);
    step(0, 0, 8'h00);
    chk_all("clr_after", 1'b0, 8'd0, 1'b0, 1'b0);

    // ---- masked compare ----
`ifdef PATTERN_DETECTOR_GEN_MASK_EN
    pattern_mask = 32'hFF00FFFF;
    exp_mask_det = 1'b1;
`else
    exp_mask_det = 1'b0;
`endif
    step(1, 0, 8'h00);
    send4(32'hAA37CCDD);
    chk("mask det", {31'd0, pattern_detected}, {31'd0, exp_mask_det});
    chk("mask sticky", {31'd0, detect_sticky}, {31'd0, exp_mask_det});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
